// File: rtl/ddr_axi_mst_arb_if.sv
// ddr_axi_mst_arb_if: AXI4 bundle (512b data, 64b addr) carrying NM ports side by side.
//   NM  number of ports packed into each request-side field ([p*W +: W])
//   IDW ID width of one port
// Request-side fields (aw*, w*, ar*) are packed per port. Response payloads
// (bid/bresp, rid/rdata/rresp/rlast) are shared by all ports, and each port
// gets its own valid/ready bit.
// Modports: master drives requests and response readies;
//           slave drives request readies and responses.
interface ddr_axi_mst_arb_if #(
    parameter int NM  = 1,
    parameter int IDW = 16
);
    logic [NM*IDW-1:0] awid;
    logic [NM*64-1:0]  awaddr;
    logic [NM*8-1:0]   awlen;
    logic [NM*3-1:0]   awsize;
    logic [NM*2-1:0]   awburst;
    logic [NM-1:0]     awvalid, awready;
    logic [NM*512-1:0] wdata;
    logic [NM*64-1:0]  wstrb;
    logic [NM-1:0]     wlast, wvalid, wready;
    logic [IDW-1:0]    bid;
    logic [1:0]        bresp;
    logic [NM-1:0]     bvalid, bready;
    logic [NM*IDW-1:0] arid;
    logic [NM*64-1:0]  araddr;
    logic [NM*8-1:0]   arlen;
    logic [NM*3-1:0]   arsize;
    logic [NM*2-1:0]   arburst;
    logic [NM-1:0]     arvalid, arready;
    logic [IDW-1:0]    rid;
    logic [511:0]      rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic [NM-1:0]     rvalid, rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input  bid, bresp, bvalid, output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
        input  rid, rdata, rresp, rlast, rvalid, output rready
    );
    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
        input  wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready
    );
endinterface

// File: rtl/ddr_axi_mst_arb.sv
// ddr_axi_mst_arb: 2:1 AXI4 arbiter sharing one DDR slave port between two CL masters.
//   AW/AR: round-robin grant, master index placed in the ID MSB on the DDR side.
//   W:     routed in AW-grant order via a small order FIFO (one bit per granted AW).
//   B/R:   routed back by the ID MSB; payload broadcast, valid steered.
// Ports:
//   clk_core  clock (posedge)
//   rst_n     asynchronous active-low reset
//   s_if      slave modport, NM=2, IDW=ID_W   (the two CL masters)
//   m_if      master modport, NM=1, IDW=ID_W+1 (DDR port)
// Parameters: ID_W (master ID width), WFIFO_DEPTH (power of 2, >= 2).
// Build option: define DDR_ARB_FIXED_PRI_EN to give master 0 strict priority
// on AW and AR instead of round-robin.
module ddr_axi_mst_arb #(
    parameter int ID_W        = 15,
    parameter int WFIFO_DEPTH = 8
) (
    input  logic              clk_core,
    input  logic              rst_n,
    ddr_axi_mst_arb_if.slave  s_if,
    ddr_axi_mst_arb_if.master m_if
);
    localparam int PW = $clog2(WFIFO_DEPTH);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

    logic fifo_full, fifo_empty, w_sel, w_pop;
    logic aw_win, ar_win, aw_grant, ar_grant;

    // ------------------------------------------------------------------
    // Winner selection (only meaningful while at least one valid is high)
    // ------------------------------------------------------------------
`ifdef DDR_ARB_FIXED_PRI_EN
    assign aw_win = ~s_if.awvalid[0];
    assign ar_win = ~s_if.arvalid[0];
`else
    // rr_*_q holds the last granted master; reset to 1 so master 0 takes the first tie.
    logic rr_aw_q, rr_ar_q;
    assign aw_win = (&s_if.awvalid) ? ~rr_aw_q : s_if.awvalid[1];
    assign ar_win = (&s_if.arvalid) ? ~rr_ar_q : s_if.arvalid[1];

    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            rr_aw_q <= 1'b1;
            rr_ar_q <= 1'b1;
        end else begin
            if (aw_grant) rr_aw_q <= aw_win;
            if (ar_grant) rr_ar_q <= ar_win;
        end
    end
`endif

    // ------------------------------------------------------------------
    // AW FSM: grant in IDLE, present on DDR in HOLD until accepted.
    // s_awready is a registered one-cycle pulse that lands in the first HOLD
    // cycle, while the granted master still holds its request.
    // ------------------------------------------------------------------
    state_e          aw_st_q, aw_st_d;
    logic [1:0]      awready_q, awready_d;
    logic [ID_W:0]   awid_q;
    logic [63:0]     awaddr_q;
    logic [7:0]      awlen_q;
    logic [2:0]      awsize_q;
    logic [1:0]      awburst_q;

    always_comb begin
        aw_st_d   = aw_st_q;
        awready_d = 2'b00;
        aw_grant  = 1'b0;
        case (aw_st_q)
            IDLE: if ((|s_if.awvalid) && !fifo_full) begin
                aw_grant  = 1'b1;
                awready_d = aw_win ? 2'b10 : 2'b01;
                aw_st_d   = HOLD;
            end
            HOLD: if (m_if.awready) aw_st_d = IDLE;
            default: aw_st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            aw_st_q   <= IDLE;
            awready_q <= 2'b00;
            awid_q    <= '0;
            awaddr_q  <= '0;
            awlen_q   <= '0;
            awsize_q  <= '0;
            awburst_q <= '0;
        end else begin
            aw_st_q   <= aw_st_d;
            awready_q <= awready_d;
            if (aw_grant) begin
                awid_q    <= {aw_win, aw_win ? s_if.awid[2*ID_W-1 -: ID_W] : s_if.awid[ID_W-1:0]};
                awaddr_q  <= aw_win ? s_if.awaddr[127:64] : s_if.awaddr[63:0];
                awlen_q   <= aw_win ? s_if.awlen[15:8]    : s_if.awlen[7:0];
                awsize_q  <= aw_win ? s_if.awsize[5:3]    : s_if.awsize[2:0];
                awburst_q <= aw_win ? s_if.awburst[3:2]   : s_if.awburst[1:0];
            end
        end
    end

    assign s_if.awready  = awready_q;
    assign m_if.awvalid  = (aw_st_q == HOLD);
    assign m_if.awid     = awid_q;
    assign m_if.awaddr   = awaddr_q;
    assign m_if.awlen    = awlen_q;
    assign m_if.awsize   = awsize_q;
    assign m_if.awburst  = awburst_q;

    // ------------------------------------------------------------------
    // AR FSM: same shape as AW, no order FIFO.
    // ------------------------------------------------------------------
    state_e          ar_st_q, ar_st_d;
    logic [1:0]      arready_q, arready_d;
    logic [ID_W:0]   arid_q;
    logic [63:0]     araddr_q;
    logic [7:0]      arlen_q;
    logic [2:0]      arsize_q;
    logic [1:0]      arburst_q;

    always_comb begin
        ar_st_d   = ar_st_q;
        arready_d = 2'b00;
        ar_grant  = 1'b0;
        case (ar_st_q)
            IDLE: if (|s_if.arvalid) begin
                ar_grant  = 1'b1;
                arready_d = ar_win ? 2'b10 : 2'b01;
                ar_st_d   = HOLD;
            end
            HOLD: if (m_if.arready) ar_st_d = IDLE;
            default: ar_st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            ar_st_q   <= IDLE;
            arready_q <= 2'b00;
            arid_q    <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            arburst_q <= '0;
        end else begin
            ar_st_q   <= ar_st_d;
            arready_q <= arready_d;
            if (ar_grant) begin
                arid_q    <= {ar_win, ar_win ? s_if.arid[2*ID_W-1 -: ID_W] : s_if.arid[ID_W-1:0]};
                araddr_q  <= ar_win ? s_if.araddr[127:64] : s_if.araddr[63:0];
                arlen_q   <= ar_win ? s_if.arlen[15:8]    : s_if.arlen[7:0];
                arsize_q  <= ar_win ? s_if.arsize[5:3]    : s_if.arsize[2:0];
                arburst_q <= ar_win ? s_if.arburst[3:2]   : s_if.arburst[1:0];
            end
        end
    end

    assign s_if.arready  = arready_q;
    assign m_if.arvalid  = (ar_st_q == HOLD);
    assign m_if.arid     = arid_q;
    assign m_if.araddr   = araddr_q;
    assign m_if.arlen    = arlen_q;
    assign m_if.arsize   = arsize_q;
    assign m_if.arburst  = arburst_q;

    // ------------------------------------------------------------------
    // W-order FIFO: one master-index bit per granted AW, popped on wlast.
    // ------------------------------------------------------------------
    logic [WFIFO_DEPTH-1:0] ord_q;
    logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [PW:0]            cnt_q;

    assign fifo_full  = (cnt_q == (PW+1)'(WFIFO_DEPTH));
    assign fifo_empty = (cnt_q == '0);
    assign w_sel      = ord_q[rd_ptr_q];
    assign w_pop      = m_if.wvalid & m_if.wready & m_if.wlast;

    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            ord_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (aw_grant) begin
                ord_q[wr_ptr_q] <= aw_win;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (w_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({aw_grant, w_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // W mux follows the FIFO head; nothing moves while the FIFO is empty.
    assign m_if.wdata  = w_sel ? s_if.wdata[1023:512] : s_if.wdata[511:0];
    assign m_if.wstrb  = w_sel ? s_if.wstrb[127:64]   : s_if.wstrb[63:0];
    assign m_if.wlast  = s_if.wlast[w_sel];
    assign m_if.wvalid = !fifo_empty && s_if.wvalid[w_sel];
    assign s_if.wready = (!fifo_empty && m_if.wready) ? (w_sel ? 2'b10 : 2'b01) : 2'b00;

    // ------------------------------------------------------------------
    // B / R return paths, steered by the ID MSB.
    // ------------------------------------------------------------------
    logic b_sel, r_sel;
    assign b_sel        = m_if.bid[ID_W];
    assign s_if.bvalid  = m_if.bvalid ? (b_sel ? 2'b10 : 2'b01) : 2'b00;
    assign s_if.bid     = m_if.bid[ID_W-1:0];
    assign s_if.bresp   = m_if.bresp;
    assign m_if.bready  = s_if.bready[b_sel];

    assign r_sel        = m_if.rid[ID_W];
    assign s_if.rvalid  = m_if.rvalid ? (r_sel ? 2'b10 : 2'b01) : 2'b00;
    assign s_if.rid     = m_if.rid[ID_W-1:0];
    assign s_if.rdata   = m_if.rdata;
    assign s_if.rresp   = m_if.rresp;
    assign s_if.rlast   = m_if.rlast;
    assign m_if.rready  = s_if.rready[r_sel];
endmodule

// File: tb/tb_ddr_axi_mst_arb.sv
// Self-checking bench for ddr_axi_mst_arb (ID_W=15, WFIFO_DEPTH=8).
module tb_ddr_axi_mst_arb;
    localparam int ID_W  = 15;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ddr_axi_mst_arb_if #(.NM(2), .IDW(ID_W))   s_if ();
    ddr_axi_mst_arb_if #(.NM(1), .IDW(ID_W+1)) m_if ();

    ddr_axi_mst_arb #(.ID_W(ID_W), .WFIFO_DEPTH(DEPTH)) dut (
        .clk_core (clk),
        .rst_n    (rst_n),
        .s_if     (s_if),
        .m_if     (m_if)
    );

    int npass = 0;
    int ntot  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic idle_inputs();
        s_if.awid = '0; s_if.awaddr = '0; s_if.awlen = '0; s_if.awsize = '0; s_if.awburst = '0;
        s_if.awvalid = '0; s_if.wdata = '0; s_if.wstrb = '0; s_if.wlast = '0; s_if.wvalid = '0;
        s_if.bready = '0; s_if.arid = '0; s_if.araddr = '0; s_if.arlen = '0; s_if.arsize = '0;
        s_if.arburst = '0; s_if.arvalid = '0; s_if.rready = '0;
        m_if.awready = '0; m_if.wready = '0; m_if.bid = '0; m_if.bresp = '0; m_if.bvalid = '0;
        m_if.arready = '0; m_if.rid = '0; m_if.rdata = '0; m_if.rresp = '0; m_if.rlast = 1'b0;
        m_if.rvalid = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // ------------------------------------------------------------------
    // Stream reference model: per-master AW lists with their W beats; the
    // expected DDR order is derived from the arbitration rule alone.
    // ------------------------------------------------------------------
    typedef struct {
        logic [14:0] id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
    } aw_t;
    typedef struct {
        logic [511:0] d;
        logic [63:0]  s;
        logic         l;
    } wb_t;

    aw_t aws [2][16];
    wb_t wbs [2][64];
    int  naw [2];
    int  nwb [2];
    int  ordm [32];
    int  ordk [32];
    int  nord;
    wb_t expw [128];
    int  nexpw;

    task automatic gen_streams(input int n0, input int n1, input int maxlen);
        int left [2];
        int wc [2];
        int turn;
        int m;
        naw[0] = n0; naw[1] = n1;
        for (int mm = 0; mm < 2; mm++) begin
            nwb[mm] = 0;
            for (int k = 0; k < naw[mm]; k++) begin
                aws[mm][k].id   = 15'($urandom);
                aws[mm][k].addr = {$urandom, $urandom};
                aws[mm][k].len  = 8'($urandom_range(0, maxlen));
                aws[mm][k].size = 3'($urandom);
                for (int b = 0; b <= int'(aws[mm][k].len); b++) begin
                    wbs[mm][nwb[mm]].d = rnd512();
                    wbs[mm][nwb[mm]].s = {$urandom, $urandom};
                    wbs[mm][nwb[mm]].l = (b == int'(aws[mm][k].len));
                    nwb[mm]++;
                end
            end
        end
        // Both masters stay backlogged, so with round-robin the grants alternate
        // starting at master 0; with fixed priority master 0 drains first.
        left[0] = 0; left[1] = 0; turn = 0; nord = 0;
        while (left[0] < naw[0] || left[1] < naw[1]) begin
`ifdef DDR_ARB_FIXED_PRI_EN
            m = (left[0] < naw[0]) ? 0 : 1;
`else
            if (left[0] < naw[0] && left[1] < naw[1]) m = turn;
            else m = (left[0] < naw[0]) ? 0 : 1;
            turn = 1 - m;
`endif
            ordm[nord] = m; ordk[nord] = left[m]; nord++; left[m]++;
        end
        wc[0] = 0; wc[1] = 0; nexpw = 0;
        for (int o = 0; o < nord; o++) begin
            for (int b = 0; b <= int'(aws[ordm[o]][ordk[o]].len); b++) begin
                expw[nexpw] = wbs[ordm[o]][wc[ordm[o]]];
                nexpw++; wc[ordm[o]]++;
            end
        end
    endtask

    task automatic run_stream(input bit rnd);
        int  hd [2];
        int  wh [2];
        int  ao, wo, cyc, bi, ri;
        bit  ahs [2];
        bit  whs [2];
        aw_t e;
        hd[0] = 0; hd[1] = 0; wh[0] = 0; wh[1] = 0; ao = 0; wo = 0; cyc = 0;
        while ((ao < nord || wo < nexpw) && cyc < 3000) begin
            for (int m = 0; m < 2; m++) begin
                s_if.awvalid[m] = (hd[m] < naw[m]);
                if (hd[m] < naw[m]) begin
                    s_if.awid[m*ID_W +: ID_W] = aws[m][hd[m]].id;
                    s_if.awaddr[m*64 +: 64]   = aws[m][hd[m]].addr;
                    s_if.awlen[m*8 +: 8]      = aws[m][hd[m]].len;
                    s_if.awsize[m*3 +: 3]     = aws[m][hd[m]].size;
                end
                s_if.wvalid[m] = (wh[m] < nwb[m]);
                if (wh[m] < nwb[m]) begin
                    s_if.wdata[m*512 +: 512] = wbs[m][wh[m]].d;
                    s_if.wstrb[m*64 +: 64]   = wbs[m][wh[m]].s;
                    s_if.wlast[m]            = wbs[m][wh[m]].l;
                end
            end
            m_if.awready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            m_if.wready  = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            m_if.bid = 16'($urandom); m_if.bvalid = 1'($urandom); m_if.bresp = 2'($urandom);
            s_if.bready = 2'($urandom);
            m_if.rid = 16'($urandom); m_if.rvalid = 1'($urandom); m_if.rlast = 1'($urandom);
            m_if.rdata = rnd512(); s_if.rready = 2'($urandom);
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                ahs[m] = s_if.awvalid[m] && s_if.awready[m];
                whs[m] = s_if.wvalid[m] && s_if.wready[m];
            end
            chk("awready onehot", 64'($countones(s_if.awready) <= 1), 64'd1);
            if (m_if.awvalid && m_if.awready) begin
                if (ao < nord) begin
                    e = aws[ordm[ao]][ordk[ao]];
                    chk("aw id", 64'(m_if.awid), 64'({1'(ordm[ao]), e.id}));
                    chk("aw addr", m_if.awaddr, e.addr);
                    chk("aw len", 64'(m_if.awlen), 64'(e.len));
                    chk("aw size", 64'(m_if.awsize), 64'(e.size));
                end else chk("aw extra grant", 64'(ao), 64'(nord));
                ao++;
            end
            if (m_if.wvalid && m_if.wready) begin
                if (wo < nexpw) begin
                    chk("w data", 64'(m_if.wdata == expw[wo].d), 64'd1);
                    chk("w strb", m_if.wstrb, expw[wo].s);
                    chk("w last", 64'(m_if.wlast), 64'(expw[wo].l));
                end else chk("w extra beat", 64'(wo), 64'(nexpw));
                wo++;
            end
            bi = int'(m_if.bid[ID_W]);
            chk("b valid route", 64'(s_if.bvalid), m_if.bvalid ? 64'(2'b01 << bi) : 64'd0);
            chk("b id", 64'(s_if.bid), 64'(m_if.bid[ID_W-1:0]));
            chk("b ready route", 64'(m_if.bready), 64'(s_if.bready[bi]));
            ri = int'(m_if.rid[ID_W]);
            chk("r valid route", 64'(s_if.rvalid), m_if.rvalid ? 64'(2'b01 << ri) : 64'd0);
            chk("r ready route", 64'(m_if.rready), 64'(s_if.rready[ri]));
            chk("r data/last", 64'(s_if.rdata == m_if.rdata && s_if.rlast == m_if.rlast), 64'd1);
            tick();
            cyc++;
            for (int m = 0; m < 2; m++) begin
                if (ahs[m]) hd[m]++;
                if (whs[m]) wh[m]++;
            end
        end
        chk("stream aw count", 64'(ao), 64'(nord));
        chk("stream w count", 64'(wo), 64'(nexpw));
        s_if.awvalid = '0; s_if.wvalid = '0; m_if.bvalid = '0; m_if.rvalid = '0;
        m_if.awready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("no extra aw", 64'(m_if.awvalid), 64'd0);
            tick();
        end
    endtask

    // ------------------------------------------------------------------
    // Table of B/R routing vectors.
    // ------------------------------------------------------------------
    typedef struct {
        bit          is_r;
        logic [15:0] id;
        logic        v;
        logic [1:0]  rdy;
        logic [1:0]  ev;
        logic [14:0] eid;
        logic        erdy;
    } vec_t;

    vec_t vt [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit  ok, seen;
        int  n;

        vt[0] = '{1'b0, 16'h0005, 1'b1, 2'b11, 2'b01, 15'h0005, 1'b1};
        vt[1] = '{1'b0, 16'h8123, 1'b1, 2'b01, 2'b10, 15'h0123, 1'b0};
        vt[2] = '{1'b0, 16'h8123, 1'b0, 2'b10, 2'b00, 15'h0123, 1'b1};
        vt[3] = '{1'b1, 16'h8012, 1'b1, 2'b10, 2'b10, 15'h0012, 1'b1};
        vt[4] = '{1'b1, 16'h7fff, 1'b1, 2'b10, 2'b01, 15'h7fff, 1'b0};
        vt[5] = '{1'b1, 16'hffff, 1'b1, 2'b11, 2'b10, 15'h7fff, 1'b1};

        // Reset state, with requests and W beats pending during reset.
        idle_inputs();
        s_if.awvalid = 2'b11; s_if.arvalid = 2'b11; s_if.wvalid = 2'b11;
        m_if.wready = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        chk("rst m_awvalid", 64'(m_if.awvalid), 64'd0);
        chk("rst m_arvalid", 64'(m_if.arvalid), 64'd0);
        chk("rst s_awready", 64'(s_if.awready), 64'd0);
        chk("rst s_arready", 64'(s_if.arready), 64'd0);
        chk("rst s_wready", 64'(s_if.wready), 64'd0);
        chk("rst m_wvalid", 64'(m_if.wvalid), 64'd0);
        do_reset();

        // Empty FIFO: an early W beat is not forwarded.
        s_if.wvalid = 2'b11; m_if.wready = 1'b1;
        @(negedge clk);
        chk("empty fifo m_wvalid", 64'(m_if.wvalid), 64'd0);
        chk("empty fifo s_wready", 64'(s_if.wready), 64'd0);
        tick();
        idle_inputs();

        // Table-driven B/R routing.
        foreach (vt[i]) begin
            if (vt[i].is_r) begin
                m_if.rid = vt[i].id; m_if.rvalid = vt[i].v; s_if.rready = vt[i].rdy;
                m_if.bvalid = 1'b0;
            end else begin
                m_if.bid = vt[i].id; m_if.bvalid = vt[i].v; s_if.bready = vt[i].rdy;
                m_if.rvalid = 1'b0;
            end
            #2;
            if (vt[i].is_r) begin
                chk("tbl r valid", 64'(s_if.rvalid), 64'(vt[i].ev));
                chk("tbl r id", 64'(s_if.rid), 64'(vt[i].eid));
                chk("tbl r ready", 64'(m_if.rready), 64'(vt[i].erdy));
            end else begin
                chk("tbl b valid", 64'(s_if.bvalid), 64'(vt[i].ev));
                chk("tbl b id", 64'(s_if.bid), 64'(vt[i].eid));
                chk("tbl b ready", 64'(m_if.bready), 64'(vt[i].erdy));
            end
        end
        idle_inputs();

        // 1: simultaneous single-beat AWs, then B routed to each master.
        do_reset();
        gen_streams(1, 1, 0);
        run_stream(1'b0);
        m_if.bid = {1'b0, aws[0][0].id}; m_if.bvalid = 1'b1; s_if.bready = 2'b11;
        #2;
        chk("t1 b0 valid", 64'(s_if.bvalid), 64'h1);
        chk("t1 b0 id", 64'(s_if.bid), 64'(aws[0][0].id));
        m_if.bid = {1'b1, aws[1][0].id};
        #2;
        chk("t1 b1 valid", 64'(s_if.bvalid), 64'h2);
        chk("t1 b1 id", 64'(s_if.bid), 64'(aws[1][0].id));
        idle_inputs();

        // 2 (and fixed-priority build): both masters stream 8 AWs.
        do_reset();
        gen_streams(8, 8, 3);
        run_stream(1'b1);

        // Randomized streams with random DDR back-pressure.
        for (int it = 0; it < 4; it++) begin
            do_reset();
            gen_streams($urandom_range(1, 10), $urandom_range(1, 10), 3);
            run_stream(1'b1);
        end

        // 3: FIFO full blocks the 9th AW until a wlast handshake.
        do_reset();
        m_if.awready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            s_if.awvalid[0] = 1'b1; s_if.awid[14:0] = 15'(k); s_if.awlen[7:0] = 8'd0;
            seen = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                @(negedge clk);
                seen = s_if.awready[0];
                tick();
            end
            chk("t3 aw accepted", 64'(seen), 64'd1);
            s_if.awvalid[0] = 1'b0;
        end
        s_if.awvalid[0] = 1'b1; s_if.awid[14:0] = 15'h9;
        ok = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (s_if.awready[0] || m_if.awvalid) ok = 1'b0;
            tick();
        end
        chk("t3 full blocks aw", 64'(ok), 64'd1);
        s_if.wvalid[0] = 1'b1; s_if.wlast[0] = 1'b1; s_if.wdata[511:0] = rnd512();
        m_if.wready = 1'b1;
        @(negedge clk);
        chk("t3 w fwd", 64'(m_if.wvalid && s_if.wready[0]), 64'd1);
        chk("t3 w data", 64'(m_if.wdata == s_if.wdata[511:0]), 64'd1);
        tick();
        s_if.wvalid[0] = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 5 && !seen; c++) begin
            @(negedge clk);
            seen = s_if.awready[0];
            tick();
        end
        chk("t3 9th aw after pop", 64'(seen), 64'd1);
        idle_inputs();

        // 4: master 1 AR, ID tagging, 4 R beats.
        do_reset();
        m_if.arready = 1'b1;
        s_if.arvalid[1] = 1'b1; s_if.arid[29:15] = 15'h12; s_if.arlen[15:8] = 8'd3;
        tick();
        @(negedge clk);
        chk("t4 ar latency", 64'(m_if.arvalid), 64'd1);
        chk("t4 m_arid", 64'(m_if.arid), 64'h8012);
        chk("t4 m_arlen", 64'(m_if.arlen), 64'd3);
        chk("t4 s_arready", 64'(s_if.arready), 64'h2);
        tick();
        s_if.arvalid[1] = 1'b0;
        s_if.rready = 2'b10;
        for (int b = 0; b < 4; b++) begin
            m_if.rid = 16'h8012; m_if.rvalid = 1'b1; m_if.rlast = (b == 3);
            m_if.rdata = 512'(b + 100);
            @(negedge clk);
            chk("t4 r valid", 64'(s_if.rvalid), 64'h2);
            chk("t4 r id", 64'(s_if.rid), 64'h12);
            chk("t4 r last", 64'(s_if.rlast), 64'(b == 3));
            chk("t4 r data", 64'(s_if.rdata), 64'(b + 100));
            chk("t4 m_rready", 64'(m_if.rready), 64'd1);
            tick();
        end
        idle_inputs();

        // 5: DDR stalls AW for 5 cycles, then reset mid-burst.
        do_reset();
        s_if.awvalid[0] = 1'b1; s_if.awid[14:0] = 15'h55; s_if.awaddr[63:0] = 64'h1234_5678_9abc_def0;
        tick();
        @(negedge clk);
        chk("t5 m_awvalid", 64'(m_if.awvalid), 64'd1);
        chk("t5 awready pulse", 64'(s_if.awready), 64'h1);
        tick();
        s_if.awvalid[0] = 1'b0;
        s_if.awvalid[1] = 1'b1; s_if.awid[29:15] = 15'h66;
        s_if.arvalid[0] = 1'b1;
        n = 0;
        repeat (5) begin
            @(negedge clk);
            if (m_if.awvalid && m_if.awid == 16'h0055 && m_if.awaddr == 64'h1234_5678_9abc_def0
                && s_if.awready == 2'b00) n++;
            tick();
        end
        chk("t5 aw stable no pulse", 64'(n), 64'd5);
        s_if.wvalid[0] = 1'b1; m_if.wready = 1'b1; s_if.wlast[0] = 1'b0;
        @(negedge clk);
        chk("t5 ar granted", 64'(m_if.arvalid), 64'd1);
        chk("t5 w fwd pre-reset", 64'(m_if.wvalid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5 async m_awvalid", 64'(m_if.awvalid), 64'd0);
        chk("t5 async m_arvalid", 64'(m_if.arvalid), 64'd0);
        chk("t5 async m_wvalid", 64'(m_if.wvalid), 64'd0);
        chk("t5 async s_wready", 64'(s_if.wready), 64'd0);
        tick();
        s_if.awvalid = '0; s_if.arvalid = '0;
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        chk("t5 fifo empty after rst", 64'(m_if.wvalid), 64'd0);
        tick();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
